if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the static pipeline CPU; the read-side master of the instruction memory.
- Drives the memory's enable, write-enable and word address, and samples the combinational read data in the same cycle.
- Holds fetched instructions in a 2-entry buffer and hands them to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, and a halt request.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- BUF_DEPTH, 2, instruction buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_ena  output  1  memory enable; high only in a fetch cycle.
- imem_wena  output  1  memory write enable; constant 0 (read-only master).
- imem_addr  output  32  word address = {2'b00, pc[31:2]}.
- imem_data  input  32  read data, valid in the same cycle as imem_ena=1; the block never drives this bus.
- redirect  input  1  branch/jump taken; load redirect_pc and flush.
- redirect_pc  input  32  target byte address.
- halt_req  input  1  stop fetching after the current cycle.
- id_ready  input  1  decode accepts the buffer head this cycle.
- id_valid  output  1  buffer head is valid.
- id_instr  output  32  instruction at the buffer head.
- id_pc  output  32  byte PC of id_instr.
- misalign_err  output  1  sticky; set when redirect_pc[1:0] != 0.

Behaviour:
- Reset values (async, rst=1):
  - pc=RESET_PC, state=S_IDLE, count=0.
  - id_valid=0, id_instr=0, id_pc=0.
  - imem_ena=0, imem_wena=0, imem_addr=0, misalign_err=0.
- FSM states: S_IDLE, S_RUN, S_HALT.
  - S_IDLE: one cycle after reset release, no fetch; next state is S_RUN.
  - S_RUN: fetch when (count<2) or (count==2 and pop), where pop = id_valid & id_ready.
  - S_HALT: imem_ena=0. The buffer still drains to decode. Only a redirect leaves S_HALT, returning to S_RUN.
- Fetch cycle:
  - imem_ena=1 and imem_addr from the current pc, combinationally.
  - At the clock edge, {imem_data, pc} is pushed to the buffer and pc <= pc+4.
  - Fetch-to-id_valid latency is 1 cycle.
- No-fetch cycle: imem_ena=0 and imem_addr holds its last value.
- Buffer:
  - FIFO order, with id_instr/id_pc presented from the head.
  - Push and pop in the same cycle with count==2: count stays 2 and ordering is preserved.
  - Push on an empty buffer: the entry becomes the head next cycle.
- pc arithmetic: 32-bit, wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
- Redirect has highest priority, over fetch, halt and pop:
  - That cycle: imem_ena=0, the buffer is flushed (count=0, id_valid=0 next cycle), pc <= {redirect_pc[31:2], 2'b00}, state=S_RUN.
  - A pop that coincides with a redirect is still counted as consumed by decode.
  - If redirect_pc[1:0]!=0, misalign_err is set and stays set until rst.
- halt_req:
  - Sampled in S_RUN. The fetch in that same cycle still completes, then the state goes to S_HALT.
  - Ignored in a cycle where redirect=1.
- Reset mid-operation: all state returns to reset values immediately, including buffer contents and misalign_err.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined, adds two outputs, reset to 0 and saturating at all-ones:
  - perf_fetch_cnt[31:0]: counts cycles with imem_ena=1.
  - perf_stall_cnt[31:0]: counts S_RUN cycles with no fetch and no redirect.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package if_pkg holds:
  - state encoding: S_IDLE=2'd0, S_RUN=2'd1, S_HALT=2'd2;
  - INSTR_W=32, PC_STEP=4;
  - the NOP constant 32'h0000_0000.
- One natural sub-module: if_instr_buf, a 2-entry synchronous FIFO carrying {pc, instr} with push/pop/flush, count and head outputs.

Test Plan:
1. Reset release, imem preloaded with words 0x11,0x22,0x33 and id_ready=1 -> S_IDLE 1 cycle, imem_addr=0,1,2 on successive cycles, id_instr=0x11/pc 0x0, 0x22/pc 0x4, 0x33/pc 0x8, one per cycle.
2. id_ready=0 for 5 cycles -> exactly 2 fetches, then imem_ena=0 and id_instr held at 0x11; with id_ready=1, order is 0x11, 0x22, 0x33 with no gaps.
3. redirect=1 with redirect_pc=0x40 while count=2 -> imem_ena=0 that cycle, id_valid=0 next cycle, then fetch at imem_addr=0x10, id_pc=0x40.
4. redirect_pc=0x42 -> misalign_err=1 and sticky, fetch at pc 0x40; a later aligned redirect leaves misalign_err=1.
5. halt_req=1 in the same cycle as redirect=1 -> halt ignored; later halt_req alone -> one more fetch, then imem_ena=0 and the buffer drains; redirect to 0x0 resumes.
6. rst asserted mid-fetch with count=1 -> id_valid=0, imem_ena=0 and pc=RESET_PC immediately (async); with IF_FETCH_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch unit and its buffer.
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } buf_entry_t;

endpackage

// File: rtl/if_instr_buf.sv
// Two-entry FIFO of {pc, instr} between fetch and decode; flush empties it.
module if_instr_buf
  import if_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  buf_entry_t push_data,
  output logic [1:0] count,
  output buf_entry_t head
);

  buf_entry_t mem [2];
  logic       rd_ptr;
  logic       wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '{pc: 32'h0, instr: NOP};
      mem[1] <= '{pc: 32'h0, instr: NOP};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // The caller only pushes into a full buffer when it pops the same cycle.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator: drives imem, buffers two words, hands them to decode.
// Optional performance counters are enabled with IF_FETCH_PERF_EN.
//
// Decode handshake: id_valid/id_instr/id_pc describe the buffer head; the head is
// consumed in any cycle where id_valid && id_ready at the rising edge. id_valid never
// depends on id_ready, and the head stays stable until it is consumed or flushed.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_ena,
  output logic               imem_wena,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt_req,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic               misalign_err,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
`endif
  output fetch_state_e       state_dbg
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  addr_q;
  logic [1:0]   count;
  buf_entry_t   head;
  logic         pop;
  logic         fetch;

  assign pop   = id_valid & id_ready;
  assign fetch = (state_q == S_RUN) && !redirect &&
                 ((count < BUF_DEPTH[1:0]) || pop);

  assign imem_ena  = fetch;
  assign imem_wena = 1'b0;
  assign imem_addr = fetch ? {2'b00, pc_q[31:2]} : addr_q;

  assign id_valid  = (count != 2'd0);
  assign id_instr  = head.instr;
  assign id_pc     = head.pc;
  assign state_dbg = state_q;

  if_instr_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (fetch),
    .pop       (pop & ~redirect),
    .flush     (redirect),
    .push_data ('{pc: pc_q, instr: imem_data}),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      if (fetch) begin
        pc_q   <= pc_q + PC_STEP;
        addr_q <= {2'b00, pc_q[31:2]};
      end
      // Redirect outranks halt; fetch is already suppressed in that cycle.
      if (redirect) begin
        pc_q    <= {redirect_pc[31:2], 2'b00};
        state_q <= S_RUN;
        if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE:  state_q <= S_RUN;
          S_RUN:   if (halt_req) state_q <= S_HALT;
          S_HALT:  state_q <= S_HALT;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (fetch && perf_fetch_cnt != 32'hFFFF_FFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state_q == S_RUN && !fetch && !redirect && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
